// File: rtl/ysyx_22050058_pipe_ctrl.sv
// Pipeline control for the 5-stage RV64 core: stall merging, EX redirect sequencing,
// simulation-stop halt, stall watchdog and performance counters.
module ysyx_22050058_pipe_ctrl #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned STALL_TIMEOUT = 1024,
    parameter int unsigned CNT_W         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallreq_if_i,
    input  logic            stallreq_id_i,
    input  logic            stallreq_ex_i,
    input  logic            stallreq_mem_i,
    input  logic            ex_isjump_i,
    input  logic [XLEN-1:0] ex_jumpaddr_i,
    input  logic            wb_dpicstop_i,
    output logic [5:0]      stall_o,
    output logic            flush_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            halted_o,
    output logic            hang_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned WD_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(STALL_TIMEOUT);

    typedef enum logic [1:0] {StRun, StFlush, StHalt} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [5:0]        w_stall;
    logic              w_flush;
    logic              w_redir;
    logic              w_accept;
    logic              w_stalled;
    logic [XLEN-1:0]   r_tgt;
    logic [WD_W-1:0]   r_wd;
    logic [WD_W-1:0]   w_wd_next;
    logic              r_hang;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    always_comb begin
        w_stall      = 6'b000000;
        w_flush      = 1'b0;
        w_redir      = 1'b0;
        w_accept     = 1'b0;
        w_state_next = r_state;
        unique case (r_state)
            StRun: begin
                if (stallreq_mem_i) begin
                    w_stall = 6'b011111;
                end else if (stallreq_ex_i) begin
                    w_stall = 6'b001111;
                end else if (stallreq_id_i) begin
                    w_stall = 6'b000111;
                end else if (stallreq_if_i) begin
                    w_stall = 6'b000011;
                end
                // IF/ID holds do not block a resolved jump; the flush discards them anyway
                w_accept = ex_isjump_i && !stallreq_ex_i && !stallreq_mem_i && !wb_dpicstop_i;
                if (wb_dpicstop_i) begin
                    w_state_next = StHalt;
                end else if (w_accept) begin
                    w_state_next = StFlush;
                end
            end
            StFlush: begin
                if (wb_dpicstop_i) begin
                    w_state_next = StHalt;
                    if (stallreq_mem_i) begin
                        w_stall = 6'b011111;
                    end
                end else if (stallreq_mem_i) begin
                    w_stall = 6'b011111;
                end else begin
                    // Younger stage requests belong to wrong-path instructions
                    w_flush      = 1'b1;
                    w_redir      = 1'b1;
                    w_state_next = StRun;
                end
            end
            StHalt: begin
                w_stall = 6'b111111;
            end
            default: begin
                w_state_next = StRun;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tgt <= '0;
        end else if (w_accept) begin
            r_tgt <= ex_jumpaddr_i;
        end
    end

    assign w_stalled = |w_stall;

    always_comb begin
        w_wd_next = r_wd;
        if (r_state != StHalt) begin
            if (!w_stalled) begin
                w_wd_next = '0;
            end else if (r_wd != WD_LIMIT) begin
                w_wd_next = r_wd + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd   <= '0;
            r_hang <= 1'b0;
        end else begin
            r_wd <= w_wd_next;
            if (w_wd_next == WD_LIMIT) begin
                r_hang <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((r_state == StRun) && w_stalled) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_o          = w_stall;
    assign flush_o          = w_flush;
    assign redirect_valid_o = w_redir;
    assign redirect_pc_o    = w_redir ? r_tgt : '0;
    assign halted_o         = (r_state == StHalt);
    assign hang_o           = r_hang;
    assign stall_cnt_o      = r_stall_cnt;
    assign flush_cnt_o      = r_flush_cnt;

endmodule

// File: tb/tb_ysyx_22050058_pipe_ctrl.sv
// Scoreboard bench for ysyx_22050058_pipe_ctrl: a cycle model pushes expected outputs,
// which are popped and compared at the falling edge.
module tb_ysyx_22050058_pipe_ctrl;

    localparam int unsigned XLEN = 64;
    localparam int unsigned TO   = 8;
    localparam int unsigned CW   = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s_if, s_id, s_ex, s_mem, s_jmp, s_stop;
    logic [XLEN-1:0] s_addr;
    logic [5:0]      stall;
    logic            flush, rvalid, halted, hang;
    logic [XLEN-1:0] rpc;
    logic [CW-1:0]   scnt, fcnt;

    always #5 clk = ~clk;

    ysyx_22050058_pipe_ctrl #(
        .XLEN          (XLEN),
        .STALL_TIMEOUT (TO),
        .CNT_W         (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stallreq_if_i    (s_if),
        .stallreq_id_i    (s_id),
        .stallreq_ex_i    (s_ex),
        .stallreq_mem_i   (s_mem),
        .ex_isjump_i      (s_jmp),
        .ex_jumpaddr_i    (s_addr),
        .wb_dpicstop_i    (s_stop),
        .stall_o          (stall),
        .flush_o          (flush),
        .redirect_valid_o (rvalid),
        .redirect_pc_o    (rpc),
        .halted_o         (halted),
        .hang_o           (hang),
        .stall_cnt_o      (scnt),
        .flush_cnt_o      (fcnt)
    );

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic        rvalid;
        logic [63:0] rpc;
        logic        halted;
        logic        hang;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: 0 run, 1 flush, 2 halt
    int          m_st;
    logic [63:0] m_tgt;
    int          m_wd;
    logic        m_hang;
    logic [31:0] m_scnt, m_fcnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st   = 0;
        m_tgt  = '0;
        m_wd   = 0;
        m_hang = 1'b0;
        m_scnt = '0;
        m_fcnt = '0;
    endtask

    // Starts just after a rising edge, ends just after the next one.
    task automatic step(input logic i_if, input logic i_id, input logic i_ex, input logic i_mem,
                        input logic jmp, input logic [63:0] addr, input logic stop);
        exp_t e;
        exp_t got;
        int   nst;
        logic acc;
        s_if = i_if; s_id = i_id; s_ex = i_ex; s_mem = i_mem;
        s_jmp = jmp; s_addr = addr; s_stop = stop;
        e   = '0;
        acc = 1'b0;
        nst = m_st;
        if (m_st == 0) begin
            if (i_mem)      e.stall = 6'b011111;
            else if (i_ex)  e.stall = 6'b001111;
            else if (i_id)  e.stall = 6'b000111;
            else if (i_if)  e.stall = 6'b000011;
            acc = jmp && !i_ex && !i_mem && !stop;
            nst = stop ? 2 : (acc ? 1 : 0);
        end else if (m_st == 1) begin
            if (i_mem) begin
                e.stall = 6'b011111;
                nst = stop ? 2 : 1;
            end else if (stop) begin
                nst = 2;
            end else begin
                e.flush  = 1'b1;
                e.rvalid = 1'b1;
                e.rpc    = m_tgt;
                nst      = 0;
            end
        end else begin
            e.stall  = 6'b111111;
            e.halted = 1'b1;
        end
        e.hang = m_hang;
        e.scnt = m_scnt;
        e.fcnt = m_fcnt;
        sb.push_back(e);

        @(negedge clk);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            got = sb.pop_front();
            check("stall_o", 64'(stall), 64'(got.stall));
            check("flush_o", 64'(flush), 64'(got.flush));
            check("redirect_valid_o", 64'(rvalid), 64'(got.rvalid));
            check("redirect_pc_o", rpc, got.rpc);
            check("halted_o", 64'(halted), 64'(got.halted));
            check("hang_o", 64'(hang), 64'(got.hang));
            check("stall_cnt_o", 64'(scnt), 64'(got.scnt));
            check("flush_cnt_o", 64'(fcnt), 64'(got.fcnt));
        end

        @(posedge clk);
        if (m_st == 0 && e.stall != 6'd0) m_scnt = m_scnt + 1;
        if (e.flush) m_fcnt = m_fcnt + 1;
        if (m_st != 2) begin
            if (e.stall != 6'd0) begin
                if (m_wd < int'(TO)) m_wd++;
            end else begin
                m_wd = 0;
            end
            if (m_wd == int'(TO)) m_hang = 1'b1;
        end
        if (acc) m_tgt = addr;
        m_st = nst;
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 64'd0, 0);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock edge.
    task automatic do_reset();
        s_if = 0; s_id = 0; s_ex = 0; s_mem = 0; s_jmp = 0; s_stop = 0; s_addr = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_stall_o", 64'(stall), 64'd0);
        check("rst_flush_o", 64'(flush), 64'd0);
        check("rst_redirect_valid_o", 64'(rvalid), 64'd0);
        check("rst_redirect_pc_o", rpc, 64'd0);
        check("rst_halted_o", 64'(halted), 64'd0);
        check("rst_hang_o", 64'(hang), 64'd0);
        check("rst_stall_cnt_o", 64'(scnt), 64'd0);
        check("rst_flush_cnt_o", 64'(fcnt), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        s_if = 0; s_id = 0; s_ex = 0; s_mem = 0; s_jmp = 0; s_stop = 0; s_addr = '0;
        model_reset();
        #2;
        check("por_stall_o", 64'(stall), 64'd0);
        check("por_halted_o", 64'(halted), 64'd0);
        check("por_flush_cnt_o", 64'(fcnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Stall priority: mem beats if, then if alone
        step(1, 0, 0, 1, 0, 64'd0, 0);
        step(1, 0, 0, 0, 0, 64'd0, 0);
        idle();
        check("stall_cnt_two", 64'(scnt), 64'd2);

        // Plain jump: one-cycle redirect on the following cycle
        step(0, 0, 0, 0, 1, 64'h8000_0040, 0);
        idle();
        idle();
        check("flush_cnt_one", 64'(fcnt), 64'd1);

        // Jump blocked by EX stall for 3 cycles
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1, 64'h8000_1000, 0);
        step(0, 0, 0, 0, 1, 64'h8000_1000, 0);
        idle();

        // Jump accepted despite IF stall, then MEM holds the redirect for 2 cycles
        step(1, 0, 0, 0, 1, 64'h8000_2220, 0);
        step(0, 0, 0, 1, 0, 64'd0, 0);
        step(1, 1, 1, 1, 1, 64'hdead_beef, 0);
        step(1, 1, 1, 0, 1, 64'hdead_beef, 0);
        idle();

        // Watchdog with ID stall held
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 64'd0, 0);
        idle();
        idle();
        check("hang_sticky", 64'(hang), 64'd1);

        // Reset in the middle of a pending redirect
        step(0, 0, 0, 0, 1, 64'h8000_3330, 0);
        do_reset();
        idle();
        idle();

        // Random traffic without stop
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0), {$urandom, $urandom}, 0);
        end
        do_reset();

        // Stop in the same cycle as an acceptable jump
        step(0, 0, 0, 0, 1, 64'h8000_4440, 1);
        idle();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 64'h8000_5550, 0);
        check("halt_no_flush", 64'(fcnt), 64'd0);

        // Stop while a redirect is pending
        do_reset();
        step(0, 0, 0, 0, 1, 64'h8000_6660, 0);
        step(0, 0, 0, 0, 0, 64'd0, 1);
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22050058_pipe_ctrl.md
Name: ysyx_22050058_pipe_ctrl

Overview:
Pipeline control block for the 5-stage RV64 core (IF/ID/EX/MEM/WB).
- Merges per-stage stall requests into one stall vector.
- Sequences branch/jump redirects out of EX with a registered flush cycle.
- Halts the pipeline when the simulation-stop instruction retires.
- Keeps a stall watchdog and two performance counters.

Parameters:
- XLEN, 64, width of the PC and redirect address.
- STALL_TIMEOUT, 1024, number of consecutive stalled cycles that flags a hang.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- stallreq_if_i  in  1  IF stall request (fetch not ready)
- stallreq_id_i  in  1  ID stall request (load-use hazard)
- stallreq_ex_i  in  1  EX stall request (multi-cycle op)
- stallreq_mem_i  in  1  MEM stall request (data access not done)
- ex_isjump_i  in  1  EX resolved taken branch/jump
- ex_jumpaddr_i  in  XLEN  EX target address
- wb_dpicstop_i  in  1  stop instruction retiring in WB
- stall_o  out  6  hold per stage; bit0=PC, 1=IF/ID, 2=ID/EX, 3=EX/MEM, 4=MEM/WB, 5=WB
- flush_o  out  1  write bubbles into IF/ID, ID/EX and EX/MEM at this edge
- redirect_valid_o  out  1  PC loads redirect_pc_o at this edge
- redirect_pc_o  out  XLEN  redirect target
- halted_o  out  1  sticky pipeline halt
- hang_o  out  1  sticky watchdog flag
- stall_cnt_o  out  CNT_W  total cycles with stall_o!=0 in RUN
- flush_cnt_o  out  CNT_W  number of flushes issued

Behaviour:
- Reset (async): state=RUN. All outputs are 0. The latched target and all counters are 0.
- States: RUN, FLUSH, HALT.
- RUN stall vector is combinational, with fixed priority mem > ex > id > if:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000011
  - none: 0
  - A stalled stage holds; the stage after it receives a bubble.
- Jump acceptance in RUN: accepted only when ex_isjump_i=1 and stallreq_ex_i=0 and stallreq_mem_i=0. IF/ID stall requests do not block acceptance.
- On acceptance, ex_jumpaddr_i is latched and the next state is FLUSH.
- In the accept cycle itself, no flush or redirect is output.
- FLUSH with stallreq_mem_i=1:
  - Stay in FLUSH; stall_o=6'b011111.
  - flush_o=0; redirect_valid_o=0.
  - The latched target is held.
- FLUSH with stallreq_mem_i=0:
  - flush_o=1, redirect_valid_o=1, redirect_pc_o=latched target, stall_o=0.
  - Next state is RUN.
  - stallreq_if/id/ex and ex_isjump_i are ignored, because those are wrong-path instructions.
  - flush_cnt_o increments.
- Redirect penalty: 2 cycles (accept cycle plus FLUSH cycle).
- wb_dpicstop_i=1 in any state: next state is HALT. This has priority over jump acceptance and over FLUSH completion.
- HALT: stall_o=6'b111111, flush_o=0, redirect_valid_o=0, halted_o=1. Only reset exits HALT.
- redirect_pc_o is 0 whenever redirect_valid_o=0.
- Watchdog: a consecutive-stall counter increments each cycle stall_o!=0 in RUN or FLUSH. It clears on any cycle with stall_o==0.
  - When the counter reaches STALL_TIMEOUT, hang_o is set and stays set until reset.
  - The counter saturates at STALL_TIMEOUT.
  - HALT freezes the counter.
- stall_cnt_o counts RUN cycles with stall_o!=0.
- Both performance counters wrap modulo 2^CNT_W.
- Reset mid-FLUSH: state returns to RUN immediately and the pending redirect is dropped.

Test Plan:
- Reset asserted mid-run -> stall_o=0, flush_o=0, halted_o=0, counters 0 in the same cycle (async); release -> RUN.
- stallreq_if_i=1 and stallreq_mem_i=1 together -> stall_o=6'b011111; drop mem only -> 6'b000011; stall_cnt_o counts 2.
- ex_isjump_i=1, ex_jumpaddr_i=64'h8000_0040 -> next cycle flush_o=1, redirect_valid_o=1, redirect_pc_o=64'h8000_0040 for exactly 1 cycle; flush_cnt_o=1.
- Jump together with stallreq_ex_i=1 for 3 cycles -> no FLUSH until stallreq_ex_i drops; then the jump is accepted and FLUSH follows next cycle.
- In FLUSH, stallreq_mem_i=1 for 2 cycles -> redirect withheld and stall_o=6'b011111 for 2 cycles; then redirect to the held target.
- wb_dpicstop_i in the same cycle as an accepted jump -> HALT, stall_o=6'b111111, halted_o=1, no redirect ever.
- STALL_TIMEOUT=8 with stallreq_id_i held high -> hang_o rises after 8 stalled cycles and stays set after stallreq_id_i drops.
